ret_stack: RTL and testbench

Hardware return-address stack for the von Neumann CPU. It sits beside the program counter. On a call it captures the 12-bit return address supplied by control. On a return it drives that address back into the PC through the PC's `DATA_IN`/`LOAD` port as a registered one-cycle load pulse. Overflow and underflow are reported through sticky error flags for the controller.

---
 rtl/ret_stack.sv | 178 +++++++++++++++++
 tb/tb_ret_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack : hardware return-address stack sitting beside the program counter.
//
// A call (PUSH) captures the return address on ADDR_IN. A return (POP) drives
// the top entry back to the PC as a registered DATA_OUT value plus a
// one-cycle LOAD_OUT strobe. Over/underflow are reported as sticky flags.
//
// Ports:
//   clk       in   1                 system clock, rising edge
//   REST      in   1                 synchronous active-high reset
//   PUSH      in   1                 call request, stores ADDR_IN
//   POP       in   1                 return request, delivers top entry
//   ADDR_IN   in   AW                return address to push
//   DATA_OUT  out  AW                popped address (to PC DATA_IN)
//   LOAD_OUT  out  1                 one-cycle load strobe (to PC LOAD)
//   COUNT     out  $clog2(DEPTH+1)   number of valid entries
//   EMPTY     out  1                 COUNT == 0
//   FULL      out  1                 COUNT == DEPTH
//   OVF       out  1                 sticky overflow flag
//   UNF       out  1                 sticky underflow flag
//
// Build option:
//   RET_STACK_WRAP_EN  defined   : push on full overwrites the oldest entry
//                                  (circular), COUNT stays DEPTH, no OVF.
//                      undefined : push on full is dropped and OVF is set.
// ---------------------------------------------------------------------------
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 12
) (
    input  logic                         clk,
    input  logic                         REST,
    input  logic                         PUSH,
    input  logic                         POP,
    input  logic [AW-1:0]                ADDR_IN,
    output logic [AW-1:0]                DATA_OUT,
    output logic                         LOAD_OUT,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         OVF,
    output logic                         UNF
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);

    localparam logic [SPW-1:0] SP_ONE    = SPW'(1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]  CNT_DEPTH = CW'(DEPTH);

    // Storage and state
    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_data;
    logic           r_load;
    logic           r_ovf;
    logic           r_unf;

    // Next-state terms
    logic           w_empty;
    logic           w_full;
    logic [SPW-1:0] w_top_idx;
    logic [AW-1:0]  w_top;
    logic           w_mem_we;
    logic [SPW-1:0] w_mem_idx;
    logic [SPW-1:0] w_sp_nxt;
    logic [CW-1:0]  w_count_nxt;
    logic [AW-1:0]  w_data_nxt;
    logic           w_load_nxt;
    logic           w_ovf_set;
    logic           w_unf_set;

    assign w_empty   = (r_count == CNT_ZERO);
    assign w_full    = (r_count == CNT_DEPTH);
    // sp points at the next free slot; the natural SPW-bit wrap gives modulo DEPTH.
    assign w_top_idx = r_sp - SP_ONE;
    assign w_top     = r_mem[w_top_idx];

    // Decode the request pair into memory write, pointer, count and output updates.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_sp;
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_data_nxt  = r_data;
        w_load_nxt  = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;

        case ({PUSH, POP})
            2'b10: begin
                if (!w_full) begin
                    w_mem_we    = 1'b1;
                    w_mem_idx   = r_sp;
                    w_sp_nxt    = r_sp + SP_ONE;
                    w_count_nxt = r_count + CNT_ONE;
                end else begin
`ifdef RET_STACK_WRAP_EN
                    // Circular mode: slot at sp holds the oldest entry when full.
                    w_mem_we    = 1'b1;
                    w_mem_idx   = r_sp;
                    w_sp_nxt    = r_sp + SP_ONE;
`else
                    w_ovf_set   = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_data_nxt  = w_top;
                    w_load_nxt  = 1'b1;
                    w_sp_nxt    = w_top_idx;
                    w_count_nxt = r_count - CNT_ONE;
                end else begin
                    w_unf_set   = 1'b1;
                end
            end
            2'b11: begin
                if (!w_empty) begin
                    // Tail call: return the old top and replace it in place.
                    w_data_nxt  = w_top;
                    w_load_nxt  = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_idx   = w_top_idx;
                end else begin
                    // Nothing to return: the push still happens (DEPTH >= 2,
                    // so an empty stack is never full).
                    w_mem_we    = 1'b1;
                    w_mem_idx   = r_sp;
                    w_sp_nxt    = r_sp + SP_ONE;
                    w_count_nxt = r_count + CNT_ONE;
                    w_unf_set   = 1'b1;
                end
            end
            default: begin
                w_load_nxt  = 1'b0;
            end
        endcase
    end

    // Entry storage; contents are don't-care after reset, reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!REST && w_mem_we) begin
            r_mem[w_mem_idx] <= ADDR_IN;
        end
    end

    // Pointer, count, output and sticky flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (REST) begin
            r_sp    <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_load  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
            r_load  <= w_load_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    assign DATA_OUT = r_data;
    assign LOAD_OUT = r_load;
    assign COUNT    = r_count;
    assign EMPTY    = w_empty;
    assign FULL     = w_full;
    assign OVF      = r_ovf;
    assign UNF      = r_unf;

endmodule

// File: tb/tb_ret_stack.sv
// ---------------------------------------------------------------------------
// tb_ret_stack : self-checking bench for ret_stack. Directed call/return
// scenarios followed by a randomized request stream, all checked against a
// queue-based reference stack after every clock edge.
// Honors RET_STACK_WRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ret_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          REST;
    logic          PUSH;
    logic          POP;
    logic [AW-1:0] ADDR_IN;
    logic [AW-1:0] DATA_OUT;
    logic          LOAD_OUT;
    logic [CW-1:0] COUNT;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic          UNF;

    ret_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .REST     (REST),
        .PUSH     (PUSH),
        .POP      (POP),
        .ADDR_IN  (ADDR_IN),
        .DATA_OUT (DATA_OUT),
        .LOAD_OUT (LOAD_OUT),
        .COUNT    (COUNT),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .OVF      (OVF),
        .UNF      (UNF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [AW-1:0] q[$];
    logic [AW-1:0] m_data;
    logic          m_load;
    logic          m_ovf;
    logic          m_unf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the rules of one edge to the reference stack.
    task automatic model_edge(input logic rst, input logic push, input logic pop,
                              input logic [AW-1:0] addr);
        if (rst) begin
            q.delete();
            m_data = '0;
            m_load = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            m_load = 1'b0;
            if (push && pop) begin
                if (q.size() > 0) begin
                    m_data = q[$];
                    m_load = 1'b1;
                    q[$]   = addr;
                end else begin
                    q.push_back(addr);
                    m_unf = 1'b1;
                end
            end else if (pop) begin
                if (q.size() > 0) begin
                    m_data = q.pop_back();
                    m_load = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end else if (push) begin
                if (q.size() < DEPTH) begin
                    q.push_back(addr);
                end else begin
`ifdef RET_STACK_WRAP_EN
                    void'(q.pop_front());
                    q.push_back(addr);
`else
                    m_ovf = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".DATA_OUT"}, 32'(DATA_OUT), 32'(m_data));
        chk({tag, ".LOAD_OUT"}, 32'(LOAD_OUT), 32'(m_load));
        chk({tag, ".COUNT"},    32'(COUNT),    32'(q.size()));
        chk({tag, ".EMPTY"},    32'(EMPTY),    32'(q.size() == 0));
        chk({tag, ".FULL"},     32'(FULL),     32'(q.size() == DEPTH));
        chk({tag, ".OVF"},      32'(OVF),      32'(m_ovf));
        chk({tag, ".UNF"},      32'(UNF),      32'(m_unf));
    endtask

    // Drive one cycle of requests, clock it, then check 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic push,
                        input logic pop, input logic [AW-1:0] addr);
        REST    = rst;
        PUSH    = push;
        POP     = pop;
        ADDR_IN = addr;
        @(posedge clk);
        model_edge(rst, push, pop, addr);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [AW-1:0] held;
        REST = 1'b1; PUSH = 1'b0; POP = 1'b0; ADDR_IN = '0;
        q.delete();
        m_data = '0; m_load = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);

        // Reset held for two cycles, all outputs zero
        step("reset0", 1'b1, 1'b0, 1'b0, 12'h000);
        step("reset1", 1'b1, 1'b0, 1'b0, 12'h000);
        chk("reset.COUNT_zero", 32'(COUNT), 32'd0);
        chk("reset.DATA_zero",  32'(DATA_OUT), 32'd0);

        // Single call/return
        step("call",   1'b0, 1'b1, 1'b0, 12'h006);
        step("ret",    1'b0, 1'b0, 1'b1, 12'h000);
        chk("ret.data_const", 32'(DATA_OUT), 32'h006);
        step("idle",   1'b0, 1'b0, 1'b0, 12'h000);

        // LIFO order with back-to-back pops
        step("lifo.p1", 1'b0, 1'b1, 1'b0, 12'h010);
        step("lifo.p2", 1'b0, 1'b1, 1'b0, 12'h020);
        step("lifo.p3", 1'b0, 1'b1, 1'b0, 12'h030);
        step("lifo.r1", 1'b0, 1'b0, 1'b1, 12'h000);
        chk("lifo.r1_const", 32'(DATA_OUT), 32'h030);
        step("lifo.r2", 1'b0, 1'b0, 1'b1, 12'h000);
        chk("lifo.r2_const", 32'(DATA_OUT), 32'h020);
        step("lifo.r3", 1'b0, 1'b0, 1'b1, 12'h000);
        chk("lifo.r3_const", 32'(DATA_OUT), 32'h010);
        step("lifo.idle", 1'b0, 1'b0, 1'b0, 12'h000);

        // Underflow: DATA_OUT must hold, UNF sticky
        held = DATA_OUT;
        step("unf.pop",  1'b0, 1'b0, 1'b1, 12'h000);
        chk("unf.data_hold", 32'(DATA_OUT), 32'(held));
        step("unf.idle", 1'b0, 1'b0, 1'b0, 12'h000);
        step("unf.push", 1'b0, 1'b1, 1'b0, 12'h055);
        step("unf.pop2", 1'b0, 1'b0, 1'b1, 12'h000);
        // Simultaneous push/pop on empty: push only, UNF again
        step("unf.both", 1'b0, 1'b1, 1'b1, 12'h066);
        step("unf.pop3", 1'b0, 1'b0, 1'b1, 12'h000);

        // Fill, push on full, drain
        step("full.rst", 1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < DEPTH; i++) begin
            step("full.push", 1'b0, 1'b1, 1'b0, AW'(12'h100 + i));
        end
        chk("full.FULL_set", 32'(FULL), 32'd1);
        step("full.extra", 1'b0, 1'b1, 1'b0, 12'hFFF);
        chk("full.COUNT_depth", 32'(COUNT), 32'(DEPTH));
        // Tail call on a full stack never overflows
        step("full.swap", 1'b0, 1'b1, 1'b1, 12'h0AB);
        for (int i = 0; i < DEPTH; i++) begin
            step("full.pop", 1'b0, 1'b0, 1'b1, 12'h000);
        end
        step("full.idle", 1'b0, 1'b0, 1'b0, 12'h000);

        // Swap and reset mid-operation
        step("swap.rst",  1'b1, 1'b0, 1'b0, 12'h000);
        step("swap.p1",   1'b0, 1'b1, 1'b0, 12'h030);
        step("swap.p2",   1'b0, 1'b1, 1'b0, 12'h040);
        step("swap.both", 1'b0, 1'b1, 1'b1, 12'h050);
        chk("swap.data_const", 32'(DATA_OUT), 32'h040);
        chk("swap.count_const", 32'(COUNT), 32'd2);
        step("swap.pop",  1'b0, 1'b0, 1'b1, 12'h000);
        chk("swap.pop_const", 32'(DATA_OUT), 32'h050);
        step("swap.rstpop", 1'b1, 1'b0, 1'b1, 12'h000);
        chk("swap.rst_load", 32'(LOAD_OUT), 32'd0);

        // Randomized request stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r_rst;
            logic r_push;
            logic r_pop;
            r_rst  = ($urandom_range(0, 59) == 0);
            r_push = ($urandom_range(0, 99) < 50);
            r_pop  = ($urandom_range(0, 99) < 45);
            step("rand", r_rst, r_push, r_pop, AW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
